// File: rtl/regfile_scan_checker_pkg.sv
// Shared definitions for the register-file run-and-scan checker:
// controller state encoding, trace entry layout and default widths.
package regfile_scan_checker_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_REG_AW      = 5;
    localparam int DEF_CYCLE_W     = 10;
    localparam int DEF_TRACE_DEPTH = 16;

    // Controller states. RUN lets the processor execute, SCAN issues one
    // register index per cycle, CMP drains the last compare, DONE holds results.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_SCAN = 3'd2,
        ST_CMP  = 3'd3,
        ST_DONE = 3'd4
    } scan_state_e;

    // One trace record at the default widths: when it happened, which
    // register was written and with what value.
    typedef struct packed {
        logic [DEF_CYCLE_W-1:0]    cycle;
        logic [DEF_REG_AW-1:0]     reg_idx;
        logic [DEF_DATA_WIDTH-1:0] data;
    } trace_entry_t;

    // The controller owns the machine while running, scanning or draining.
    function automatic logic is_busy(input scan_state_e s);
        return (s == ST_RUN) || (s == ST_SCAN) || (s == ST_CMP);
    endfunction

    // Only the scan and drain phases steal the register file read port.
    function automatic logic is_test_mode(input scan_state_e s);
        return (s == ST_SCAN) || (s == ST_CMP);
    endfunction

endpackage

// File: rtl/scan_trace_fifo.sv
// Synchronous trace FIFO with full/empty flags. A push into a full FIFO is
// dropped and latches a sticky overflow flag, unless a pop happens in the
// same cycle, in which case both take effect. A pop on an empty FIFO is a
// no-op. clear_i empties the FIFO and clears the overflow flag.
module scan_trace_fifo
    import regfile_scan_checker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_TRACE_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             overflow_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop    = push_i && full_o && !do_pop;

    // Read and write pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Sticky record that at least one entry was lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Entry storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign valid_o    = !empty;
    assign data_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/regfile_scan_checker.sv
// Run-and-check harness: lets the processor run for a programmed number of
// cycles, traces register writes, then scans the register file A port
// against an expected-value ROM and reports pass/fail, error count and the
// first mismatch.
// Optional feature macro: REGFILE_SCAN_TRACE_EN enables the write monitor
// and trace FIFO; without it the trace outputs are tied to zero.
//
// Trace port handshake: an entry is offered while trace_valid is high and
// is consumed on any rising clock edge where trace_valid and trace_ready
// are both high; trace_ready with trace_valid low has no effect.
module regfile_scan_checker
    import regfile_scan_checker_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int CYCLE_W     = DEF_CYCLE_W,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [CYCLE_W-1:0]                num_cycles,
    input  logic                              rwe,
    input  logic [REG_AW-1:0]                 rd,
    input  logic [DATA_WIDTH-1:0]             rData,
    output logic                              test_mode,
    output logic [REG_AW-1:0]                 rs1_test,
    input  logic [DATA_WIDTH-1:0]             regA,
    output logic [REG_AW-1:0]                 exp_addr,
    input  logic [DATA_WIDTH-1:0]             exp_data,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [$clog2(NUM_REGS+1)-1:0]     error_count,
    output logic [REG_AW-1:0]                 first_fail_reg,
    output logic [DATA_WIDTH-1:0]             first_fail_actual,
    output logic                              trace_valid,
    input  logic                              trace_ready,
    output logic [CYCLE_W-1:0]                trace_cycle,
    output logic [REG_AW-1:0]                 trace_reg,
    output logic [DATA_WIDTH-1:0]             trace_data,
    output logic                              trace_overflow
);

    localparam int ECW = $clog2(NUM_REGS+1);

    scan_state_e          state_q;
    logic [CYCLE_W-1:0]   budget_q;
    logic [CYCLE_W-1:0]   cyc_q;
    logic [REG_AW-1:0]    scan_idx_q;

    logic                 cmp_valid_q;
    logic [REG_AW-1:0]    cmp_idx_q;
    logic [DATA_WIDTH-1:0] cmp_act_q;

    logic [ECW-1:0]       err_q;
    logic [REG_AW-1:0]    ff_reg_q;
    logic [DATA_WIDTH-1:0] ff_act_q;

    logic                 start_accept;
    logic                 last_run;
    logic                 last_scan;
    logic                 cmp_mismatch;

    // start is honoured only when the controller is not busy.
    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_run     = (cyc_q == budget_q - CYCLE_W'(1));
    assign last_scan    = (scan_idx_q == REG_AW'(NUM_REGS-1));
    assign cmp_mismatch = cmp_valid_q && (cmp_act_q != exp_data);

    // Controller FSM: run-cycle counter, scan index and phase sequencing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            budget_q   <= '0;
            cyc_q      <= '0;
            scan_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_accept) begin
                        budget_q   <= num_cycles;
                        cyc_q      <= '0;
                        scan_idx_q <= '0;
                        // A zero budget skips the processor run entirely.
                        state_q    <= (num_cycles == '0) ? ST_SCAN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    cyc_q <= cyc_q + CYCLE_W'(1);
                    if (last_run) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (last_scan) begin
                        state_q <= ST_CMP;
                    end else begin
                        scan_idx_q <= scan_idx_q + REG_AW'(1);
                    end
                end
                ST_CMP: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Compare stage: capture the register value alongside its index so it
    // lines up with the ROM data, which arrives one cycle after the address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            cmp_act_q   <= '0;
        end else if (start_accept) begin
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            cmp_act_q   <= '0;
        end else if (state_q == ST_SCAN) begin
            cmp_valid_q <= 1'b1;
            cmp_idx_q   <= scan_idx_q;
            cmp_act_q   <= regA;
        end else begin
            cmp_valid_q <= 1'b0;
        end
    end

    // Result registers: error count and first-mismatch capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q    <= '0;
            ff_reg_q <= '0;
            ff_act_q <= '0;
        end else if (start_accept) begin
            err_q    <= '0;
            ff_reg_q <= '0;
            ff_act_q <= '0;
        end else if (cmp_mismatch) begin
            // One compare per register, so the guard only protects the width.
            if (err_q != ECW'(NUM_REGS)) begin
                err_q <= err_q + ECW'(1);
            end
            // A zero count means no mismatch has been recorded yet this run.
            if (err_q == '0) begin
                ff_reg_q <= cmp_idx_q;
                ff_act_q <= cmp_act_q;
            end
        end
    end

    assign test_mode         = is_test_mode(state_q);
    assign busy              = is_busy(state_q);
    assign done              = (state_q == ST_DONE);
    assign pass              = done && (err_q == '0);
    assign rs1_test          = scan_idx_q;
    assign exp_addr          = scan_idx_q;
    assign error_count       = err_q;
    assign first_fail_reg    = ff_reg_q;
    assign first_fail_actual = ff_act_q;

`ifdef REGFILE_SCAN_TRACE_EN
    // Trace record sized by this instance's parameters; same field order
    // as trace_entry_t.
    typedef struct packed {
        logic [CYCLE_W-1:0]    cycle;
        logic [REG_AW-1:0]     reg_idx;
        logic [DATA_WIDTH-1:0] data;
    } trace_word_t;

    localparam int TW = CYCLE_W + REG_AW + DATA_WIDTH;

    trace_word_t push_word;
    trace_word_t head_word;
    logic        push_en;
    logic        fifo_full_unused;

    // Only architectural writes during the run are recorded; r0 is hardwired.
    assign push_en   = (state_q == ST_RUN) && rwe && (rd != '0);
    assign push_word = '{cycle: cyc_q, reg_idx: rd, data: rData};

    scan_trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (start_accept),
        .push_i     (push_en),
        .data_i     (push_word),
        .pop_i      (trace_ready),
        .data_o     (head_word),
        .valid_o    (trace_valid),
        .full_o     (fifo_full_unused),
        .overflow_o (trace_overflow)
    );

    assign trace_cycle = head_word.cycle;
    assign trace_reg   = head_word.reg_idx;
    assign trace_data  = head_word.data;
`else
    localparam int TRACE_DEPTH_UNUSED = TRACE_DEPTH;
    logic trace_inputs_unused;

    assign trace_inputs_unused = ^{rwe, rd, rData, trace_ready};
    assign trace_valid    = 1'b0;
    assign trace_cycle    = '0;
    assign trace_reg      = '0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker with a small register-file and
// expected-ROM environment. Trace expectations collapse to zero when the
// trace feature is not built in.
module tb_regfile_scan_checker;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 10;
    localparam int TD = 4;
`ifdef REGFILE_SCAN_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic                     clock;
    logic                     reset;
    logic                     start;
    logic [CW-1:0]            num_cycles;
    logic                     rwe;
    logic [AW-1:0]            rd;
    logic [DW-1:0]            rData;
    logic                     test_mode;
    logic [AW-1:0]            rs1_test;
    logic [DW-1:0]            regA;
    logic [AW-1:0]            exp_addr;
    logic [DW-1:0]            exp_data;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [$clog2(NR+1)-1:0]  error_count;
    logic [AW-1:0]            first_fail_reg;
    logic [DW-1:0]            first_fail_actual;
    logic                     trace_valid;
    logic                     trace_ready;
    logic [CW-1:0]            trace_cycle;
    logic [AW-1:0]            trace_reg;
    logic [DW-1:0]            trace_data;
    logic                     trace_overflow;

    logic [DW-1:0] regs    [NR];
    logic [DW-1:0] exp_mem [NR];

    int checks      = 0;
    int errors      = 0;
    int edge_cnt    = 0;
    int accept_edge = 0;
    int rel         = 0;

    regfile_scan_checker #(
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .REG_AW      (AW),
        .CYCLE_W     (CW),
        .TRACE_DEPTH (TD)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .num_cycles        (num_cycles),
        .rwe               (rwe),
        .rd                (rd),
        .rData             (rData),
        .test_mode         (test_mode),
        .rs1_test          (rs1_test),
        .regA              (regA),
        .exp_addr          (exp_addr),
        .exp_data          (exp_data),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .error_count       (error_count),
        .first_fail_reg    (first_fail_reg),
        .first_fail_actual (first_fail_actual),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_cycle       (trace_cycle),
        .trace_reg         (trace_reg),
        .trace_data        (trace_data),
        .trace_overflow    (trace_overflow)
    );

    // Clock and environment: regfile A-port mux (processor rs1 held at 0)
    // and a synchronous expected-value ROM.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign regA = regs[test_mode ? rs1_test : 5'd0];

    always @(posedge clock) exp_data <= exp_mem[exp_addr];

    task automatic tick();
        @(posedge clock);
        #1;
        edge_cnt++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] tx(input logic [63:0] v);
        return TRACE_EN ? v : 64'd0;
    endfunction

    task automatic load_env();
        for (int i = 0; i < NR; i++) begin
            regs[i]    = DW'(i * 3 + 1);
            exp_mem[i] = DW'(i * 3 + 1);
        end
    endtask

    task automatic start_run(input logic [CW-1:0] n);
        num_cycles = n;
        start      = 1'b1;
        tick();
        start       = 1'b0;
        accept_edge = edge_cnt;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done && guard < 200) begin
            tick();
            guard++;
        end
        rel = edge_cnt - accept_edge;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_cycles = '0;
        rwe = 1'b0; rd = '0; rData = '0; trace_ready = 1'b0;
        load_env();
        tick();
        tick();

        // Reset values
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_done",      64'(done), 64'd0);
        check("rst_pass",      64'(pass), 64'd0);
        check("rst_test_mode", 64'(test_mode), 64'd0);
        check("rst_rs1_test",  64'(rs1_test), 64'd0);
        check("rst_exp_addr",  64'(exp_addr), 64'd0);
        check("rst_err",       64'(error_count), 64'd0);
        check("rst_ff_reg",    64'(first_fail_reg), 64'd0);
        check("rst_ff_act",    64'(first_fail_actual), 64'd0);
        check("rst_tvalid",    64'(trace_valid), 64'd0);
        check("rst_tdata",     64'(trace_data), 64'd0);
        check("rst_tovf",      64'(trace_overflow), 64'd0);
        reset = 1'b0;
        tick();

        // Run of 5 cycles: r3<-7 at cycle 1, r0<-9 at cycle 2, stray start.
        start_run(10'd5);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_tm_run",           64'(test_mode), 64'd0);
        tick();
        rwe = 1'b1; rd = 5'd3; rData = 32'd7;
        tick();
        rd = 5'd0; rData = 32'd9;
        check("t1_head_valid", 64'(trace_valid), tx(64'd1));
        check("t1_head_cycle", 64'(trace_cycle), tx(64'd1));
        check("t1_head_reg",   64'(trace_reg),   tx(64'd3));
        check("t1_head_data",  64'(trace_data),  tx(64'd7));
        start = 1'b1; num_cycles = 10'd20;
        tick();
        rwe = 1'b0; rd = '0; rData = '0; start = 1'b0; num_cycles = 10'd5;
        tick();
        check("t1_tm_last_run",  64'(test_mode), 64'd0);
        check("t1_busy_run",     64'(busy), 64'd1);
        tick();
        check("t1_tm_scan0",     64'(test_mode), 64'd1);
        check("t1_rs1_scan0",    64'(rs1_test), 64'd0);
        tick();
        check("t1_rs1_scan1",    64'(rs1_test), 64'd1);
        check("t1_addr_scan1",   64'(exp_addr), 64'd1);
        wait_done();
        check("t1_done",         64'(done), 64'd1);
        check("t1_latency",      64'(rel), 64'd38);
        check("t1_pass",         64'(pass), 64'd1);
        check("t1_err",          64'(error_count), 64'd0);
        check("t1_busy_done",    64'(busy), 64'd0);
        check("t1_tm_done",      64'(test_mode), 64'd0);
        check("t1_keep_valid",   64'(trace_valid), tx(64'd1));
        check("t1_keep_reg",     64'(trace_reg), tx(64'd3));
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        check("t1_one_entry",    64'(trace_valid), 64'd0);

        // Two mismatches: r7 and r12.
        regs[7] = 32'd11; exp_mem[7]  = 32'd10;
        regs[12] = 32'd5; exp_mem[12] = 32'd0;
        start_run(10'd2);
        check("t2_done_cleared", 64'(done), 64'd0);
        wait_done();
        check("t2_latency",      64'(rel), 64'd35);
        check("t2_err",          64'(error_count), 64'd2);
        check("t2_ff_reg",       64'(first_fail_reg), 64'd7);
        check("t2_ff_act",       64'(first_fail_actual), 64'd11);
        check("t2_pass",         64'(pass), 64'd0);
        check("t2_done",         64'(done), 64'd1);
        load_env();

        // Zero budget: straight to SCAN, writes ignored.
        start_run(10'd0);
        check("t3_tm_direct",    64'(test_mode), 64'd1);
        check("t3_busy",         64'(busy), 64'd1);
        check("t3_err_cleared",  64'(error_count), 64'd0);
        check("t3_ff_cleared",   64'(first_fail_reg), 64'd0);
        rwe = 1'b1; rd = 5'd5; rData = 32'd55;
        tick();
        rwe = 1'b0;
        wait_done();
        check("t3_latency",      64'(rel), 64'd33);
        check("t3_no_trace",     64'(trace_valid), 64'd0);
        check("t3_pass",         64'(pass), 64'd1);

        // FIFO depth 4: fill, push+pop while full, then two dropped pushes.
        start_run(10'd10);
        rwe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd    = AW'(i + 1);
            rData = 32'h100 + DW'(i);
            tick();
        end
        check("t4_full_valid",   64'(trace_valid), tx(64'd1));
        check("t4_full_ovf",     64'(trace_overflow), 64'd0);
        check("t4_head0_cycle",  64'(trace_cycle), tx(64'd0));
        check("t4_head0_reg",    64'(trace_reg), tx(64'd1));
        check("t4_head0_data",   64'(trace_data), tx(64'h100));
        rd = 5'd5; rData = 32'h104; trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        check("t4_pp_ovf",       64'(trace_overflow), 64'd0);
        check("t4_pp_cycle",     64'(trace_cycle), tx(64'd1));
        check("t4_pp_reg",       64'(trace_reg), tx(64'd2));
        check("t4_pp_data",      64'(trace_data), tx(64'h101));
        rd = 5'd6; rData = 32'h105;
        tick();
        rd = 5'd7; rData = 32'h106;
        tick();
        rwe = 1'b0; rd = '0; rData = '0;
        check("t4_ovf_set",      64'(trace_overflow), tx(64'd1));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_drain%0d_valid", k), 64'(trace_valid), tx(64'd1));
            check($sformatf("t4_drain%0d_cycle", k), 64'(trace_cycle), tx(64'(k + 1)));
            check($sformatf("t4_drain%0d_reg", k),   64'(trace_reg),   tx(64'(k + 2)));
            check($sformatf("t4_drain%0d_data", k),  64'(trace_data),  tx(64'(32'h101 + k)));
            trace_ready = 1'b1;
            tick();
            trace_ready = 1'b0;
        end
        check("t4_drained",      64'(trace_valid), 64'd0);
        wait_done();
        check("t4_latency",      64'(rel), 64'd43);
        check("t4_ovf_sticky",   64'(trace_overflow), tx(64'd1));
        check("t4_pass",         64'(pass), 64'd1);

        // Reset during SCAN after an r0 mismatch has been counted.
        regs[0] = 32'd99;
        start_run(10'd1);
        check("t5_ovf_cleared",  64'(trace_overflow), 64'd0);
        tick();
        tick();
        tick();
        check("t5_err_pre",      64'(error_count), 64'd1);
        check("t5_ff_r0_act",    64'(first_fail_actual), 64'd99);
        check("t5_tm_pre",       64'(test_mode), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_tm",       64'(test_mode), 64'd0);
        check("t5_rst_busy",     64'(busy), 64'd0);
        check("t5_rst_err",      64'(error_count), 64'd0);
        check("t5_rst_rs1",      64'(rs1_test), 64'd0);
        check("t5_rst_done",     64'(done), 64'd0);
        load_env();
        tick();
        tick();
        reset = 1'b0;
        tick();
        start_run(10'd3);
        wait_done();
        check("t5_restart_latency", 64'(rel), 64'd36);
        check("t5_restart_pass",    64'(pass), 64'd1);
        check("t5_restart_err",     64'(error_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
